// File: rtl/instr_pack_loader_pkg.sv
// Shared definitions for the instruction packer/loader: word layout, FSM
// encoding and the field-packing helper.
package instr_pack_loader_pkg;

  localparam int INSTR_W  = 37;

  localparam int DATA_MSB = 36;
  localparam int DATA_LSB = 21;
  localparam int OPC_MSB  = 20;
  localparam int OPC_LSB  = 17;
  localparam int LI_BIT   = 16;
  localparam int RW_BIT   = 15;
  localparam int A1_MSB   = 14;
  localparam int A1_LSB   = 10;
  localparam int A2_MSB   = 9;
  localparam int A2_LSB   = 5;
  localparam int A3_MSB   = 4;
  localparam int A3_LSB   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  opcode;
    logic        load_imm;
    logic        rw;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [4:0]  addr3;
  } instr_fields_t;

  function automatic logic [INSTR_W-1:0] pack_instr(input instr_fields_t f);
    logic [INSTR_W-1:0] w;
    w                    = '0;
    w[DATA_MSB:DATA_LSB] = f.data;
    w[OPC_MSB:OPC_LSB]   = f.opcode;
    w[LI_BIT]            = f.load_imm;
    w[RW_BIT]            = f.rw;
    w[A1_MSB:A1_LSB]     = f.addr1;
    w[A2_MSB:A2_LSB]     = f.addr2;
    w[A3_MSB:A3_LSB]     = f.addr3;
    return w;
  endfunction

endpackage

// File: rtl/instr_pack_loader_sync_fifo.sv
// Small first-word-fall-through FIFO; head is valid whenever empty is low.
// Push and pop are each gated internally by full/empty of the current cycle.
module sync_fifo
  import instr_pack_loader_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Entries are cleared on reset so the head reads zero while idle.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/instr_pack_loader.sv
// Packs decoded instruction fields into 37-bit words and streams them through
// a FIFO into consecutive program-memory addresses starting at base_addr.
module instr_pack_loader
  import instr_pack_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PM_AW = 8,
  parameter int CNT_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PM_AW-1:0]   base_addr,
  input  logic [CNT_W-1:0]   num_instr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic [3:0]         in_opcode,
  input  logic               in_load_imm,
  input  logic               in_rw,
  input  logic [4:0]         in_addr1,
  input  logic [4:0]         in_addr2,
  input  logic [4:0]         in_addr3,
  output logic               pm_we,
  input  logic               pm_ready,
  output logic [PM_AW-1:0]   pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [CNT_W-1:0]   accept_cnt_reg;
  logic [CNT_W-1:0]   write_cnt_reg;
  logic [PM_AW-1:0]   wr_ptr_reg;
  instr_fields_t      fields;
  logic [INSTR_W-1:0] packed_word;
  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               in_fire;
  logic               wr_fire;
  logic               load_start;

  always_comb begin
    fields.data     = in_data;
    fields.opcode   = in_opcode;
    fields.load_imm = in_load_imm;
    fields.rw       = in_rw;
    fields.addr1    = in_addr1;
    fields.addr2    = in_addr2;
    fields.addr3    = in_addr3;
  end

  assign packed_word = pack_instr(fields);

  assign in_ready   = (state_reg == ST_LOAD) && !fifo_full && (accept_cnt_reg != '0);
  assign in_fire    = in_valid && in_ready;
  assign pm_we      = !fifo_empty;
  assign wr_fire    = pm_we && pm_ready;
  assign pm_addr    = wr_ptr_reg;
  assign pm_wdata   = fifo_head;
  assign busy       = (state_reg == ST_LOAD);
  assign done       = (state_reg == ST_DONE);
  assign load_start = (state_reg == ST_IDLE) && start && (num_instr != '0);

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (in_fire),
    .push_data (packed_word),
    .pop       (wr_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (num_instr != '0) ? ST_LOAD : ST_DONE;
      // The last outstanding write completing is what ends the load.
      ST_LOAD: if (wr_fire && (write_cnt_reg == CNT_ONE)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      accept_cnt_reg <= '0;
      write_cnt_reg  <= '0;
      wr_ptr_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (load_start) begin
        wr_ptr_reg     <= base_addr;
        accept_cnt_reg <= num_instr;
        write_cnt_reg  <= num_instr;
      end else begin
        if (in_fire) accept_cnt_reg <= accept_cnt_reg - 1'b1;
        if (wr_fire) begin
          wr_ptr_reg    <= wr_ptr_reg + 1'b1;
          write_cnt_reg <= write_cnt_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_pack_loader.sv
// Directed bench for instr_pack_loader: packing, backpressure, count limits,
// address wrap, mid-load reset and start-while-busy.
module tb_instr_pack_loader;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  opc;
    logic        li;
    logic        rw;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
  } fld_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  num_instr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_opcode = '0;
  logic        in_load_imm = 1'b0;
  logic        in_rw = 1'b0;
  logic [4:0]  in_addr1 = '0;
  logic [4:0]  in_addr2 = '0;
  logic [4:0]  in_addr3 = '0;
  logic        pm_we;
  logic        pm_ready = 1'b0;
  logic [7:0]  pm_addr;
  logic [36:0] pm_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  fld_t        tab [16];
  logic        feed_en = 1'b0;
  int          feed_n = 0;
  int          feed_idx = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  wr_addr_q [$];
  logic [36:0] wr_data_q [$];

  instr_pack_loader #(.DEPTH(4), .PM_AW(8), .CNT_W(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_instr   (num_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_opcode   (in_opcode),
    .in_load_imm (in_load_imm),
    .in_rw       (in_rw),
    .in_addr1    (in_addr1),
    .in_addr2    (in_addr2),
    .in_addr3    (in_addr3),
    .pm_we       (pm_we),
    .pm_ready    (pm_ready),
    .pm_addr     (pm_addr),
    .pm_wdata    (pm_wdata),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] exp_word(input fld_t f);
    return {f.data, f.opc, f.li, f.rw, f.a1, f.a2, f.a3};
  endfunction

  // Field-set source: presents tab[feed_idx] until it is accepted.
  always begin
    @(posedge clk);
    #2;
    if (feed_en && feed_idx < feed_n) begin
      in_valid    = 1'b1;
      in_data     = tab[feed_idx].data;
      in_opcode   = tab[feed_idx].opc;
      in_load_imm = tab[feed_idx].li;
      in_rw       = tab[feed_idx].rw;
      in_addr1    = tab[feed_idx].a1;
      in_addr2    = tab[feed_idx].a2;
      in_addr3    = tab[feed_idx].a3;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Observes handshakes mid-cycle and logs one line per memory write.
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      acc_cnt++;
      feed_idx++;
    end
    if (pm_we && pm_ready) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_wdata);
      $display("WR addr=%02h data=%010h", pm_addr, pm_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_cnt  = 0;
    done_cnt = 0;
    feed_idx = 0;
  endtask

  task automatic fill_tab(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      tab[i].data = {seed, 8'(i * 17 + 1)};
      tab[i].opc  = 4'(i + 3);
      tab[i].li   = 1'(i & 1);
      tab[i].rw   = 1'(~i & 1);
      tab[i].a1   = 5'(i + seed);
      tab[i].a2   = 5'(31 - i);
      tab[i].a3   = 5'(i * 3 + 7);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start     = 1'b1;
    base_addr = b;
    num_instr = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout done=%b required=1 after %0d cycles", name, done, n);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_to_idle done=%b busy=%b required 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (pm_we !== 1'b0) begin errors++; $display("FAIL rst_pm_we got=%b exp=0", pm_we); end
    checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL rst_pm_addr got=%h exp=00", pm_addr); end
    checks++; if (pm_wdata !== 37'h0) begin errors++; $display("FAIL rst_pm_wdata got=%h exp=0", pm_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pack();
    clear_mon();
    tab[0] = '{data: 16'hABCD, opc: 4'd3, li: 1'b1, rw: 1'b0, a1: 5'd5, a2: 5'd10, a3: 5'd31};
    feed_n   = 1;
    feed_en  = 1'b1;
    pm_ready = 1'b1;
    do_start(8'h10, 9'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_done("single");
    feed_en = 1'b0;
    checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL single_nwrites got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_addr_q[0] !== 8'h10) begin errors++; $display("FAIL single_addr got=%h exp=10", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 37'h1579A7155F) begin errors++; $display("FAIL single_wdata got=%h exp=1579a7155f", wr_data_q[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int stall_bad = 0;
    clear_mon();
    fill_tab(6, 8'h5A);
    feed_n   = 6;
    feed_en  = 1'b1;
    pm_ready = 1'b0;
    do_start(8'h20, 9'd6);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pm_we === 1'b1 && (pm_addr !== 8'h20 || pm_wdata !== exp_word(tab[0]))) stall_bad++;
    end
    checks++; if (acc_cnt != 4) begin errors++; $display("FAIL bp_accepts_when_full got=%0d exp=4", acc_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    checks++; if (pm_we !== 1'b1) begin errors++; $display("FAIL bp_pm_we_stalled got=%b exp=1", pm_we); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable unstable_cycles=%0d exp=0", stall_bad); end
    pm_ready = 1'b1;
    wait_done("bp");
    feed_en = 1'b0;
    checks++; if (wr_addr_q.size() != 6) begin errors++; $display("FAIL bp_nwrites got=%0d exp=6", wr_addr_q.size()); end
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 8'(8'h20 + i) || wr_data_q[i] !== exp_word(tab[i])) begin
        errors++;
        $display("FAIL bp_write%0d got addr=%h data=%h exp addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], 8'(8'h20 + i), exp_word(tab[i]));
      end
    end
  endtask

  task automatic test_count_limit();
    clear_mon();
    fill_tab(3, 8'hC3);
    feed_n   = 3;
    feed_en  = 1'b1;
    pm_ready = 1'b1;
    do_start(8'h40, 9'd2);
    wait_done("limit");
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL limit_in_ready_idle got=%b exp=0", in_ready); end
    feed_en = 1'b0;
    checks++; if (acc_cnt != 2) begin errors++; $display("FAIL limit_accepts got=%0d exp=2", acc_cnt); end
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL limit_nwrites got=%0d exp=2", wr_addr_q.size()); end
    if (wr_addr_q.size() == 2) begin
      checks++;
      if (wr_addr_q[1] !== 8'h41 || wr_data_q[1] !== exp_word(tab[1])) begin
        errors++;
        $display("FAIL limit_last_write got addr=%h data=%h exp addr=41 data=%h", wr_addr_q[1], wr_data_q[1], exp_word(tab[1]));
      end
    end
  endtask

  task automatic test_zero();
    clear_mon();
    feed_en = 1'b0;
    do_start(8'h55, 9'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (pm_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_no_load pm_we=%b busy=%b exp 0/0", pm_we, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    checks++; if (wr_addr_q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL zero_writes got writes=%0d done_pulses=%0d exp 0/1", wr_addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    clear_mon();
    fill_tab(4, 8'h77);
    feed_n   = 4;
    feed_en  = 1'b1;
    pm_ready = 1'b1;
    do_start(8'hFE, 9'd4);
    wait_done("wrap");
    feed_en = 1'b0;
    checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL wrap_nwrites got=%0d exp=4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, wr_addr_q[i], exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_mon();
    fill_tab(5, 8'h3C);
    feed_n   = 5;
    feed_en  = 1'b1;
    pm_ready = 1'b0;
    do_start(8'h30, 9'd5);
    tick();
    tick();
    tick();
    checks++; if (acc_cnt != 3) begin errors++; $display("FAIL midrst_queued got=%0d exp=3", acc_cnt); end
    reset   = 1'b1;
    feed_en = 1'b0;
    tick();
    checks++; if (pm_we !== 1'b0) begin errors++; $display("FAIL midrst_pm_we got=%b exp=0", pm_we); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    clear_mon();
    fill_tab(2, 8'h99);
    feed_n   = 2;
    feed_en  = 1'b1;
    pm_ready = 1'b1;
    do_start(8'h60, 9'd2);
    wait_done("midrst_reload");
    feed_en = 1'b0;
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL midrst_nwrites got=%0d exp=2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 8'(8'h60 + i) || wr_data_q[i] !== exp_word(tab[i])) begin
        errors++;
        $display("FAIL midrst_write%0d got addr=%h data=%h exp addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], 8'(8'h60 + i), exp_word(tab[i]));
      end
    end
  endtask

  task automatic test_start_while_busy();
    clear_mon();
    fill_tab(3, 8'hE1);
    feed_n   = 3;
    feed_en  = 1'b1;
    pm_ready = 1'b1;
    do_start(8'h80, 9'd3);
    tick();
    do_start(8'h90, 9'd7);
    wait_done("busy_start");
    feed_en = 1'b0;
    checks++; if (wr_addr_q.size() != 3 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start_counts got writes=%0d done_pulses=%0d exp 3/1", wr_addr_q.size(), done_cnt);
    end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 8'(8'h80 + i) || wr_data_q[i] !== exp_word(tab[i])) begin
        errors++;
        $display("FAIL busy_start_write%0d got addr=%h data=%h exp addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], 8'(8'h80 + i), exp_word(tab[i]));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || pm_we !== 1'b0) begin
      errors++; $display("FAIL busy_start_idle got busy=%b pm_we=%b exp 0/0", busy, pm_we);
    end
  endtask

  initial begin
    test_reset();
    test_single_pack();
    test_backpressure();
    test_count_limit();
    test_zero();
    test_wrap();
    test_reset_mid_load();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
